// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router.
// Header-tagged FIFO that blanks its output between packets.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int PW = ADDR_W + 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [6:0]        r_pkt_cnt;
  logic [DATA_W-1:0] r_data_out;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_clr;
  logic [DATA_W:0]   w_rd_entry;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_wr_acc   = write_enb && !w_full;
  assign w_rd_acc   = read_enb && !w_empty;
  assign w_clr      = !resetn || soft_reset;
  assign w_rd_entry = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Storage is intentionally left unreset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (!w_clr && w_wr_acc)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_data_out <= w_rd_entry[DATA_W-1:0];
        // Header length field counts payload; +1 covers the parity byte.
        if (w_rd_entry[DATA_W])
          r_pkt_cnt <= 7'(w_rd_entry[DATA_W-1:2]) + 7'd1;
        else if (r_pkt_cnt != 7'd0)
          r_pkt_cnt <= r_pkt_cnt - 7'd1;
      end else if (r_pkt_cnt == 7'd0) begin
        r_data_out <= '0;
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule
